// File: rtl/ghash_pkg.sv
// Shared types and constants for the GHASH block scheduler.
// State encoding, data source select codes and lane parallelism.
package ghash_pkg;

  localparam int BLOCK_PROC_PAR = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AAD,
    ST_CT,
    ST_LEN,
    ST_DRAIN
  } state_t;

  localparam logic [1:0] SEL_AAD = 2'd0;
  localparam logic [1:0] SEL_CT  = 2'd1;
  localparam logic [1:0] SEL_LEN = 2'd2;

endpackage

// File: rtl/ghash_lane_mask_gen.sv
// Turns a remaining-block count into the group size k and its lane mask.
// k saturates at the lane count; the mask has its k low bits set.
module ghash_lane_mask_gen
  import ghash_pkg::*;
#(
  parameter int NB   = 10,
  parameter int PAR  = BLOCK_PROC_PAR,
  parameter int NB_K = $clog2(PAR) + 1
) (
  input  logic [NB-1:0]   remaining,
  output logic [NB_K-1:0] k,
  output logic [PAR-1:0]  mask
);

  always_comb begin
    if (remaining >= NB'(PAR)) k = NB_K'(PAR);
    else                       k = remaining[NB_K-1:0];
    mask = '0;
    for (int i = 0; i < PAR; i++)
      mask[i] = (NB_K'(i) < k);
  end

endmodule

// File: rtl/ghash_block_scheduler.sv
// Sequences one GHASH job: AAD groups, CT groups, then the length block,
// then waits for the control unit to report the hash as done.
module ghash_block_scheduler
  import ghash_pkg::*;
#(
  parameter int NB_N_MESSAGES       = 10,
  parameter int LOG2_BLOCK_PROC_PAR = 2,
  parameter int DRAIN_TIMEOUT       = 64,
  parameter int NB_TIMEOUT          = 7
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic                           i_start,
  input  logic [NB_N_MESSAGES-1:0]       i_n_aad,
  input  logic [NB_N_MESSAGES-1:0]       i_n_ct,
  input  logic                           i_blk_valid,
  output logic                           o_blk_ready,
  input  logic                           i_hold_msg,
  input  logic                           i_hash_done,
  output logic                           o_ghash_valid,
  output logic [(2**LOG2_BLOCK_PROC_PAR)-1:0] o_blk_mask,
  output logic [1:0]                     o_sel,
  output logic [NB_N_MESSAGES-1:0]       o_n_messages,
  output logic [NB_N_MESSAGES-1:0]       o_msg_count,
  output logic [LOG2_BLOCK_PROC_PAR-1:0] o_msg_bubbles,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_error
);

  localparam int NB   = NB_N_MESSAGES;
  localparam int PAR  = 2**LOG2_BLOCK_PROC_PAR;
  localparam int NB_K = LOG2_BLOCK_PROC_PAR + 1;

  state_t              state;
  logic [NB-1:0]       remaining;
  logic [NB-1:0]       n_ct_q;
  logic [NB_TIMEOUT-1:0] timer;
  logic [NB_K-1:0]     k;
  logic [NB-1:0]       k_ext;
  logic [NB-1:0]       k_issue;
  logic [PAR-1:0]      lane_mask;
  logic                hs;
  logic [NB:0]         total;

  ghash_lane_mask_gen #(
    .NB   (NB),
    .PAR  (PAR),
    .NB_K (NB_K)
  ) u_mask (
    .remaining (remaining),
    .k         (k),
    .mask      (lane_mask)
  );

  // One extra bit so an oversized job is detectable rather than wrapping.
  assign total = {1'b0, i_n_aad} + {1'b0, i_n_ct} + (NB+1)'(1);
  assign k_ext = {{(NB-NB_K){1'b0}}, k};

  assign o_busy      = (state != ST_IDLE);
  assign o_blk_ready = (state == ST_AAD || state == ST_CT) & ~i_hold_msg;
  assign hs          = o_blk_ready & i_blk_valid;

  always_comb begin
    o_ghash_valid = 1'b0;
    o_blk_mask    = '0;
    o_sel         = SEL_AAD;
    k_issue       = '0;
    unique case (1'b1)
      state == ST_AAD: begin
        o_ghash_valid = hs;
        o_blk_mask    = lane_mask;
        o_sel         = SEL_AAD;
        k_issue       = k_ext;
      end
      state == ST_CT: begin
        o_ghash_valid = hs;
        o_blk_mask    = lane_mask;
        o_sel         = SEL_CT;
        k_issue       = k_ext;
      end
      state == ST_LEN: begin
        o_ghash_valid = 1'b1;
        o_blk_mask    = PAR'(1);
        o_sel         = SEL_LEN;
        k_issue       = NB'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state         <= ST_IDLE;
      remaining     <= '0;
      n_ct_q        <= '0;
      timer         <= '0;
      o_n_messages  <= '0;
      o_msg_count   <= '0;
      o_msg_bubbles <= '0;
      o_done        <= 1'b0;
      o_error       <= 1'b0;
    end else begin
      o_done  <= 1'b0;
      o_error <= 1'b0;
      if (o_ghash_valid) o_msg_count <= o_msg_count + k_issue;
      unique case (state)
        ST_IDLE: if (i_start) begin
          o_msg_count   <= '0;
          o_n_messages  <= total[NB-1:0];
          o_msg_bubbles <= total[LOG2_BLOCK_PROC_PAR-1:0];
          n_ct_q        <= i_n_ct;
          if (total[NB]) begin
            o_error <= 1'b1;
          end else if (i_n_aad != '0) begin
            state     <= ST_AAD;
            remaining <= i_n_aad;
          end else if (i_n_ct != '0) begin
            state     <= ST_CT;
            remaining <= i_n_ct;
          end else begin
            state <= ST_LEN;
          end
        end
        ST_AAD, ST_CT: if (hs) begin
          if (remaining == k_ext) begin
            if (state == ST_AAD && n_ct_q != '0) begin
              state     <= ST_CT;
              remaining <= n_ct_q;
            end else begin
              state     <= ST_LEN;
              remaining <= '0;
            end
          end else begin
            remaining <= remaining - k_ext;
          end
        end
        ST_LEN: begin
          state <= ST_DRAIN;
          timer <= '0;
        end
        ST_DRAIN: begin
          if (i_hash_done) begin
            o_done <= 1'b1;
            state  <= ST_IDLE;
          end else if (timer == NB_TIMEOUT'(DRAIN_TIMEOUT - 1)) begin
            o_error <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ghash_block_scheduler.sv
// Randomized bench for ghash_block_scheduler against a queue-based model
// of the expected block-group sequence.
module tb_ghash_block_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [9:0] n_aad;
  logic [9:0] n_ct;
  logic       blk_valid;
  logic       blk_ready;
  logic       hold;
  logic       hash_done;
  logic       ghash_valid;
  logic [3:0] blk_mask;
  logic [1:0] sel;
  logic [9:0] n_messages;
  logic [9:0] msg_count;
  logic [1:0] bubbles;
  logic       busy;
  logic       done;
  logic       error;

  int checks = 0;
  int failures = 0;

  int q_sel[$];
  int q_mask[$];
  int q_k[$];

  always #5 clk = ~clk;

  ghash_block_scheduler dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_start       (start),
    .i_n_aad       (n_aad),
    .i_n_ct        (n_ct),
    .i_blk_valid   (blk_valid),
    .o_blk_ready   (blk_ready),
    .i_hold_msg    (hold),
    .i_hash_done   (hash_done),
    .o_ghash_valid (ghash_valid),
    .o_blk_mask    (blk_mask),
    .o_sel         (sel),
    .o_n_messages  (n_messages),
    .o_msg_count   (msg_count),
    .o_msg_bubbles (bubbles),
    .o_busy        (busy),
    .o_done        (done),
    .o_error       (error)
  );

  // Expected issue order: groups of up to 4 AAD, then CT, then one LEN.
  function automatic void build_model(input int na, input int nc);
    int rem;
    int kk;
    q_sel.delete();
    q_mask.delete();
    q_k.delete();
    for (int ph = 0; ph < 2; ph++) begin
      rem = (ph == 0) ? na : nc;
      while (rem > 0) begin
        kk = (rem < 4) ? rem : 4;
        q_sel.push_back(ph);
        q_mask.push_back((1 << kk) - 1);
        q_k.push_back(kk);
        rem -= kk;
      end
    end
    q_sel.push_back(2);
    q_mask.push_back(1);
    q_k.push_back(1);
  endfunction

  // mode 0: random valid/hold plus stray start/done; 1: streaming;
  // 2: streaming with hold high for cycles 1..3.
  task automatic run_job(input int na, input int nc, input int mode,
                         input int done_delay, input bit prestarted,
                         input bit chain, input int nna, input int nnc);
    int cnt;
    int cyc;
    int dc;
    int total;
    bit exp_v;
    bit exp_r;
    total = na + nc + 1;
    build_model(na, nc);
    if (!prestarted) begin
      @(posedge clk); #1;
      start = 1'b1;
      n_aad = 10'(na);
      n_ct  = 10'(nc);
    end
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0;
    cyc = 0;
    while (q_sel.size() > 0 && cyc < 5000) begin
      if (mode == 0) begin
        blk_valid = ($urandom_range(0, 3) != 0);
        hold      = ($urandom_range(0, 4) == 0);
        hash_done = ($urandom_range(0, 7) == 0);
        start     = ($urandom_range(0, 7) == 0);
      end else if (mode == 2) begin
        blk_valid = 1'b1;
        hold      = (cyc >= 1 && cyc <= 3);
      end else begin
        blk_valid = 1'b1;
        hold      = 1'b0;
      end
      @(negedge clk);
      exp_r = (q_sel[0] != 2) && !hold;
      exp_v = (q_sel[0] == 2) ? 1'b1 : (blk_valid && !hold);
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL busy cyc=%0d got=%b want=1", cyc, busy);
      end
      checks++;
      if (blk_ready !== exp_r) begin
        failures++;
        $display("FAIL ready cyc=%0d got=%b want=%b", cyc, blk_ready, exp_r);
      end
      checks++;
      if (msg_count !== 10'(cnt)) begin
        failures++;
        $display("FAIL msg_count cyc=%0d got=%0d want=%0d", cyc, msg_count, cnt);
      end
      checks++;
      if (ghash_valid !== exp_v) begin
        failures++;
        $display("FAIL ghash_valid cyc=%0d got=%b want=%b", cyc, ghash_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (sel !== 2'(q_sel[0]) || blk_mask !== 4'(q_mask[0])) begin
          failures++;
          $display("FAIL group cyc=%0d got sel=%0d mask=%b want sel=%0d mask=%b",
                   cyc, sel, blk_mask, q_sel[0], 4'(q_mask[0]));
        end
        cnt += q_k[0];
        void'(q_sel.pop_front());
        void'(q_mask.pop_front());
        void'(q_k.pop_front());
      end
      cyc++;
      @(posedge clk); #1;
      start = 1'b0;
      hash_done = 1'b0;
    end
    checks++;
    if (q_sel.size() != 0) begin
      failures++;
      $display("FAIL issue_timeout got=%0d left want=0", q_sel.size());
    end
    blk_valid = 1'b0;
    hold = 1'b0;
    if (done_delay >= 0) begin
      repeat (done_delay) begin
        @(negedge clk);
        checks++;
        if ({busy, done, error, blk_ready, ghash_valid} !== 5'b10000) begin
          failures++;
          $display("FAIL drain got busy/done/err/rdy/v=%b want=10000",
                   {busy, done, error, blk_ready, ghash_valid});
        end
        @(posedge clk); #1;
      end
      hash_done = 1'b1;
      @(posedge clk); #1;
      hash_done = 1'b0;
      if (chain) begin
        start = 1'b1;
        n_aad = 10'(nna);
        n_ct  = 10'(nnc);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
        failures++;
        $display("FAIL done_pulse got done=%b busy=%b err=%b want 1 0 0", done, busy, error);
      end
      checks++;
      if (msg_count !== 10'(total) || n_messages !== 10'(total) ||
          bubbles !== 2'(total % 4)) begin
        failures++;
        $display("FAIL totals got cnt=%0d n=%0d bub=%0d want %0d %0d %0d",
                 msg_count, n_messages, bubbles, total, total, total % 4);
      end
      if (!chain) begin
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
          failures++;
          $display("FAIL done_width got=%b want=0", done);
        end
      end
    end else begin
      dc = 0;
      @(negedge clk);
      while (busy === 1'b1 && dc < 200) begin
        dc++;
        @(posedge clk); #1;
        @(negedge clk);
      end
      checks++;
      if (dc != 64) begin
        failures++;
        $display("FAIL drain_len got=%0d want=64", dc);
      end
      checks++;
      if (error !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL timeout_err got err=%b done=%b want 1 0", error, done);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ghash_valid, blk_ready, blk_mask, sel, n_messages, msg_count,
         bubbles, busy, done, error} !== 33'd0) begin
      failures++;
      $display("FAIL reset_state got v=%b r=%b m=%b s=%0d n=%0d c=%0d b=%0d busy=%b d=%b e=%b want all 0",
               ghash_valid, blk_ready, blk_mask, sel, n_messages, msg_count,
               bubbles, busy, done, error);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_job(5, 7, 1, 3, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_empty();
    run_job(0, 0, 1, 5, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_hold();
    run_job(8, 0, 2, 2, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_overflow();
    for (int t = 0; t < 2; t++) begin
      @(posedge clk); #1;
      start = 1'b1;
      n_aad = 10'd1023;
      n_ct  = (t == 0) ? 10'd1 : 10'd0;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (error !== 1'b1 || busy !== 1'b0 || ghash_valid !== 1'b0) begin
        failures++;
        $display("FAIL overflow%0d got err=%b busy=%b v=%b want 1 0 0",
                 t, error, busy, ghash_valid);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (error !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL overflow_after%0d got err=%b busy=%b want 0 0", t, error, busy);
      end
    end
  endtask

  task automatic test_max();
    run_job(1022, 0, 1, 1, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_timeout();
    run_job(3, 2, 0, -1, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    start = 1'b1;
    n_aad = 10'd0;
    n_ct  = 10'd12;
    blk_valid = 1'b1;
    hold = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ghash_valid, blk_ready, blk_mask, sel, n_messages, msg_count,
         bubbles, busy, done, error} !== 33'd0) begin
      failures++;
      $display("FAIL reset_mid got v=%b r=%b m=%b s=%0d n=%0d c=%0d b=%0d busy=%b d=%b e=%b want all 0",
               ghash_valid, blk_ready, blk_mask, sel, n_messages, msg_count,
               bubbles, busy, done, error);
    end
    blk_valid = 1'b0;
    run_job(0, 4, 1, 2, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_random();
    int na;
    int nc;
    for (int j = 0; j < 8; j++) begin
      na = $urandom_range(0, 40);
      nc = $urandom_range(0, 40);
      run_job(na, nc, 0, $urandom_range(0, 10), 1'b0, 1'b0, 0, 0);
    end
  endtask

  task automatic test_back_to_back();
    run_job(2, 3, 0, 1, 1'b0, 1'b1, 4, 0);
    run_job(4, 0, 0, 2, 1'b1, 1'b0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    n_aad = '0;
    n_ct = '0;
    blk_valid = 1'b0;
    hold = 1'b0;
    hash_done = 1'b0;
    test_reset();
    test_basic();
    test_empty();
    test_hold();
    test_overflow();
    test_max();
    test_timeout();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
